// File: rtl/de_pipe_reg_pkg.sv
// ============================================================================
// Module   : de_pipe_reg_pkg
// Brief    : Shared MDU opcode encodings and Tnew width for the D/E register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package de_pipe_reg_pkg;

    localparam int c_TW = 2;

    localparam logic [3:0] c_MD_NONE  = 4'd0;
    localparam logic [3:0] c_MD_MULT  = 4'd1;
    localparam logic [3:0] c_MD_MULTU = 4'd2;
    localparam logic [3:0] c_MD_DIV   = 4'd3;
    localparam logic [3:0] c_MD_DIVU  = 4'd4;
    localparam logic [3:0] c_MD_MFHI  = 4'd5;
    localparam logic [3:0] c_MD_MFLO  = 4'd6;
    localparam logic [3:0] c_MD_MTHI  = 4'd7;
    localparam logic [3:0] c_MD_MTLO  = 4'd8;
    localparam logic [3:0] c_MD_MSUB  = 4'd9;
    localparam logic [3:0] c_MD_MSUBU = 4'd10;

    // Any non-none code, including undefined ones, touches HI/LO.
    function automatic logic is_md(input logic [3:0] sel);
        return sel != c_MD_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/de_stall_gen.sv
// ============================================================================
// Module   : de_stall_gen
// Brief    : Combinational D-stage stall and E-bubble selection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import de_pipe_reg_pkg::*;

module de_stall_gen (
    input  logic       data_stall,
    input  logic       md_stall,
    input  logic       flush,
    input  logic [3:0] d_md_sel,
    output logic       stall_d,
    output logic       bubble,
    output logic       stall_bubble
);

    logic w_d_is_md;

    assign w_d_is_md    = is_md(d_md_sel);
    assign stall_d      = data_stall | (md_stall & w_d_is_md);
    assign bubble       = flush | stall_d;
    // Flush outranks stall, so a coincident flush is not a stall bubble.
    assign stall_bubble = stall_d & ~flush;

endmodule

`default_nettype wire

// File: rtl/de_pipe_reg.sv
// ============================================================================
// Module   : de_pipe_reg
// Brief    : D/E pipeline register with stall/bubble insertion.
//            Optional stall-bubble counter enabled by `BUBBLE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import de_pipe_reg_pkg::*;

module de_pipe_reg #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int TW = c_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] d_pc,
    input  logic [31:0]   d_instr,
    input  logic [DW-1:0] d_rs_data,
    input  logic [DW-1:0] d_rt_data,
    input  logic [DW-1:0] d_imm,
    input  logic [AW-1:0] d_rs_addr,
    input  logic [AW-1:0] d_rt_addr,
    input  logic [AW-1:0] d_wa,
    input  logic [TW-1:0] d_tnew,
    input  logic [3:0]    d_md_sel,
    input  logic          data_stall,
    input  logic          md_stall,
    input  logic          flush,
    output logic          stall_d,
    output logic [DW-1:0] e_pc,
    output logic [31:0]   e_instr,
    output logic [DW-1:0] e_rs_data,
    output logic [DW-1:0] e_rt_data,
    output logic [DW-1:0] e_imm,
    output logic [AW-1:0] e_rs_addr,
    output logic [AW-1:0] e_rt_addr,
    output logic [AW-1:0] e_wa,
    output logic [TW-1:0] e_tnew,
    output logic [3:0]    e_md_sel,
    output logic          e_bubble
`ifdef BUBBLE_CNT_EN
    ,
    output logic [31:0]   bubble_cnt
`endif
);

    logic w_bubble;
    logic w_stall_bubble;

    de_stall_gen u_stall_gen (
        .data_stall   (data_stall),
        .md_stall     (md_stall),
        .flush        (flush),
        .d_md_sel     (d_md_sel),
        .stall_d      (stall_d),
        .bubble       (w_bubble),
        .stall_bubble (w_stall_bubble)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            e_pc      <= '0;
            e_instr   <= '0;
            e_rs_data <= '0;
            e_rt_data <= '0;
            e_imm     <= '0;
            e_rs_addr <= '0;
            e_rt_addr <= '0;
            e_wa      <= '0;
            e_tnew    <= '0;
            e_md_sel  <= c_MD_NONE;
            e_bubble  <= 1'b1;
        end else if (w_bubble) begin
            // PC rides along with the bubble so EPC stays meaningful.
            e_pc      <= d_pc;
            e_instr   <= '0;
            e_rs_data <= '0;
            e_rt_data <= '0;
            e_imm     <= '0;
            e_rs_addr <= '0;
            e_rt_addr <= '0;
            e_wa      <= '0;
            e_tnew    <= '0;
            e_md_sel  <= c_MD_NONE;
            e_bubble  <= 1'b1;
        end else begin
            e_pc      <= d_pc;
            e_instr   <= d_instr;
            e_rs_data <= d_rs_data;
            e_rt_data <= d_rt_data;
            e_imm     <= d_imm;
            e_rs_addr <= d_rs_addr;
            e_rt_addr <= d_rt_addr;
            e_wa      <= d_wa;
            e_tnew    <= d_tnew;
            e_md_sel  <= d_md_sel;
            e_bubble  <= 1'b0;
        end
    end

`ifdef BUBBLE_CNT_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (w_stall_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`else
    logic w_unused;
    assign w_unused = w_stall_bubble;
`endif

endmodule

`default_nettype wire

// File: doc/de_pipe_reg.md
Name: de_pipe_reg

Overview:
- D/E pipeline register that feeds the E-stage multiply/divide unit and ALU.
- Latches decoded D-stage fields each cycle.
- Generates the D-stage stall for two cases: register-data hazards (supplied by the hazard comparator) and HI/LO structural hazards (MDU busy or starting while D holds an MD-class op).
- On a stall it inserts a bubble into E. F/D hold is driven by its stall_d output.

Parameters:
- DW, 32, datapath width (operands, PC, immediate)
- AW, 5, register-address width
- TW, 2, Tnew field width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- d_pc  in  DW  D-stage PC
- d_instr  in  32  D-stage instruction word
- d_rs_data  in  DW  forwarded rs value
- d_rt_data  in  DW  forwarded rt value
- d_imm  in  DW  extended immediate
- d_rs_addr, d_rt_addr  in  AW  source register numbers
- d_wa  in  AW  destination register (0 = none)
- d_tnew  in  TW  cycles until the result is ready, counted from E entry
- d_md_sel  in  4  MDU opcode (md_* encoding)
- data_stall  in  1  Tuse/Tnew hazard from the comparator
- md_stall  in  1  E-stage MDU start|busy
- flush  in  1  kill the D-stage instruction (exception/eret path)
- stall_d  out  1  hold F/D
- e_pc, e_instr, e_rs_data, e_rt_data, e_imm  out  as inputs  registered copies
- e_rs_addr, e_rt_addr, e_wa  out  AW  registered copies
- e_tnew  out  TW  registered Tnew
- e_md_sel  out  4  MDU opcode to E
- e_bubble  out  1  E slot holds an inserted bubble

Behaviour:
- Reset:
  - All e_* outputs are 0, except e_md_sel = md_none and e_bubble = 1.
  - stall_d is combinational and is not registered.
- d_is_md = (d_md_sel != md_none). This covers mult, multu, div, divu, msub, msubu, mfhi, mflo, mthi and mtlo.
- stall_d = data_stall | (md_stall & d_is_md). Purely combinational, no latency.
- Per-edge priority is reset > flush > stall_d > load.
- Bubble (flush or stall_d):
  - e_instr, rs/rt data, imm, addrs, e_wa, e_tnew are set to 0.
  - e_md_sel = md_none, e_bubble = 1.
  - e_pc = d_pc, kept for exception EPC.
- Load: every e_* field takes its D value, e_tnew = d_tnew, e_bubble = 0.
- Latency: exactly 1 cycle from D to E. No internal state beyond the register.
- An MD op in E that is currently starting asserts md_stall in the same cycle. A following MD op in D therefore stalls until MDU busy clears.
- Non-MD ops pass freely while the MDU is busy.
- Simultaneous flush & stall_d: the E result is identical (bubble). stall_d stays asserted so F/D holds; the external flush logic overrides F/D.
- md_sel with an undefined code (11..15) is treated as MD-class for stalling and passed through unchanged.

Optional Feature:
- BUBBLE_CNT_EN defined:
  - Adds output bubble_cnt (32). It increments on every edge where a stall-induced bubble is inserted (not flush, not reset) and clears on reset.
  - It saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- The shared constant file holds the md_* encodings: md_none=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8, msub=9, msubu=10.
- The same file holds the Tnew width.
- One sub-module is natural: de_stall_gen (combinational stall_d and bubble-select).
- The register bank stays in the top.

Test Plan:
- Reset held 2 cycles with d_md_sel=mult → e_md_sel=md_none, e_bubble=1, all e_* data 0.
- d_md_sel=mult, d_rs_data=7, d_rt_data=6, no stalls → next edge e_md_sel=1, e_rs_data=7, e_rt_data=6, e_bubble=0.
- md_stall=1 and d_md_sel=mflo → stall_d=1; next edge e_md_sel=md_none, e_bubble=1, e_pc=d_pc. Hold this for 5 cycles, then drop md_stall → mflo loads into E.
- md_stall=1 and d_md_sel=md_none (addu, d_wa=8, d_tnew=1) → stall_d=0; next edge e_wa=8, e_tnew=1.
- data_stall=1 and flush=1 simultaneously → bubble in E and stall_d=1. With BUBBLE_CNT_EN, bubble_cnt increments by 1 on a stall-only bubble and by 0 on a flush-only bubble.
- Mid-operation reset (stall active, e_md_sel=div) → next edge everything returns to reset values and bubble_cnt=0.
